// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Counter widths are sized for the largest legal MAX_BURST and HOLD_CYCLES settings.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

    localparam logic [7:0] DEFAULT_TERM = 8'h0A;

    localparam int MAX_BURST_LIMIT = 127;
    localparam int HOLD_LIMIT      = 255;
    localparam int BURST_W         = $clog2(MAX_BURST_LIMIT + 1);
    localparam int HOLD_W          = $clog2(HOLD_LIMIT + 1);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req at or after
// rr_ptr+1, wrapping, as a one-hot vector (all-zero when req is empty).
module uart_rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner
);

    // NOTE: winner gets a default before the loop so every path assigns it and no latch is inferred.
    // Scanning from the farthest offset down lets the nearest candidate overwrite the others.
    always_comb begin
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && i == (int'(rr_ptr) + k) % NREQ) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging NREQ byte streams onto one UART transmit port.
// Define UART_TX_ARB_LOCK_EN to keep the grant for a whole message (TERM, MAX_BURST, HOLD_CYCLES).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NREQ        = 2,
    parameter int         MAX_BURST   = 64,
    parameter int         HOLD_CYCLES = 16,
    parameter logic [7:0] TERM        = DEFAULT_TERM
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant
);

    localparam int PTR_W = $clog2(NREQ);
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int EFF_BURST = LOCK_EN ? MAX_BURST : 1;

    arb_state_e         state_q,    state_d;
    logic [NREQ-1:0]    grant_q,    grant_d;
    logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [BURST_W-1:0] burst_q,    burst_d;
    logic [HOLD_W-1:0]  hold_q,     hold_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q,  tx_data_d;

    logic [NREQ-1:0]    winner;
    logic [PTR_W-1:0]   gnt_idx;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               out_free;
    logic               accept;
    logic               release_now;
    logic [BURST_W-1:0] burst_inc;
    logic [HOLD_W-1:0]  hold_inc;

    uart_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .winner (winner)
    );

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // The output register can take a new byte when empty or being drained this cycle.
    assign sel_valid = |(req_valid & grant_q);
    assign out_free  = ~tx_valid_q | tx_ready;
    assign req_ready = (state_q == ST_SERVE && out_free) ? grant_q : '0;
    assign accept    = |(req_valid & req_ready);
    assign burst_inc = burst_q + 1'b1;
    assign hold_inc  = hold_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        hold_d      = hold_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        release_now = 1'b0;

        // The output byte is independent of the grant, so a release never drops it.
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_SERVE;
                    grant_d = winner;
                    burst_d = '0;
                    hold_d  = '0;
                end
            end
            ST_SERVE: begin
                if (accept) begin
                    burst_d     = burst_inc;
                    hold_d      = '0;
                    release_now = (LOCK_EN && sel_data == TERM) ||
                                  (burst_inc == BURST_W'(EFF_BURST));
                end else if (LOCK_EN && !sel_valid) begin
                    hold_d      = hold_inc;
                    release_now = (hold_inc == HOLD_W'(HOLD_CYCLES));
                end
                // A TERM byte that is also the last of the burst still releases once.
                if (release_now) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = gnt_idx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_W'(NREQ - 1);
            burst_q    <= '0;
            hold_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            hold_q     <= hold_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign grant    = grant_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed and randomized streams checked against a
// message-level ordering model; follows UART_TX_ARB_LOCK_EN like the RTL build.
module tb_uart_tx_arbiter;

    localparam int         NREQ        = 2;
    localparam int         MAX_BURST   = 64;
    localparam int         HOLD_CYCLES = 16;
    localparam logic [7:0] TERM        = 8'h0A;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int EFF_BURST = LOCK_EN ? MAX_BURST : 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [NREQ-1:0]   grant;

    logic [7:0]      mem [NREQ][256];
    int              len       [NREQ];
    int              gap_after [NREQ];
    int              gap_len   [NREQ];
    logic [7:0]      exp_q[$];
    logic [7:0]      got_q[$];
    logic [NREQ-1:0] exp_own[$];
    logic [NREQ-1:0] got_own[$];
    int              ready_mode;
    int              n_checks;
    int              n_fail;

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .MAX_BURST   (MAX_BURST),
        .HOLD_CYCLES (HOLD_CYCLES),
        .TERM        (TERM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(input int r, input string s);
        for (int k = 0; k < s.len(); k++) mem[r][k] = s[k];
        len[r]       = s.len();
        gap_after[r] = -1;
        gap_len[r]   = 0;
    endtask

    task automatic load_random(input int r, input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = ($urandom_range(0, 7) == 0) ? TERM : 8'($urandom_range(32, 126));
            mem[r][k] = b;
        end
        len[r]       = n;
        gap_after[r] = -1;
        gap_len[r]   = 0;
    endtask

    task automatic expect_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endtask

    // Message-level model: every requester keeps its valid up while it has bytes,
    // so the tx order depends only on the arbitration and release rules.
    task automatic build_expected();
        int pos [NREQ];
        int ptr;
        int w;
        int cnt;
        logic [7:0] b;
        exp_q.delete();
        exp_own.delete();
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        ptr = NREQ - 1;
        while (1) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (ptr + k) % NREQ;
                if (w < 0 && pos[c] < len[c]) w = c;
            end
            if (w < 0) break;
            exp_own.push_back(NREQ'(1) << w);
            cnt = 0;
            while (pos[w] < len[w]) begin
                b = mem[w][pos[w]];
                pos[w]++;
                exp_q.push_back(b);
                cnt++;
                if ((LOCK_EN && b == TERM) || cnt == EFF_BURST) break;
            end
            ptr = w;
        end
    endtask

    task automatic run_stream(input string name, input int budget);
        int              rd      [NREQ];
        int              gap_cnt [NREQ];
        bit              pend;
        bit              stall;
        bit              done;
        bit              consumed;
        logic [7:0]      pend_byte;
        logic [7:0]      prev_data;
        logic [NREQ-1:0] last_grant;
        got_q.delete();
        got_own.delete();
        for (int i = 0; i < NREQ; i++) begin
            rd[i]      = 0;
            gap_cnt[i] = 0;
        end
        pend = 0; stall = 0; done = 0;
        pend_byte = '0; prev_data = '0; last_grant = '0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gap_cnt[i] > 0) begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = '0;
                    gap_cnt[i]--;
                end else if (rd[i] < len[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = mem[i][rd[i]];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = '0;
                end
            end
            case (ready_mode)
                0:       tx_ready = ($urandom_range(0, 3) != 0);
                1:       tx_ready = 1'b1;
                default: tx_ready = !(cyc >= 4 && cyc < 14);
            endcase
            @(negedge clk);
            check({name, ":tx_valid"}, tx_valid, pend || stall);
            if (pend) check({name, ":latency_data"}, tx_data, pend_byte);
            else if (stall) check({name, ":stall_data"}, tx_data, prev_data);
            if (tx_valid && !tx_ready) check({name, ":stall_ready"}, req_ready, 0);
            check({name, ":ready_vs_grant"}, req_ready & ~grant, 0);
            if (grant != '0 && last_grant == '0) got_own.push_back(grant);
            last_grant = grant;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            stall     = tx_valid && !tx_ready;
            prev_data = tx_data;
            pend      = 0;
            consumed  = 1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pend      = 1;
                    pend_byte = req_data[8*i +: 8];
                    rd[i]++;
                    if (rd[i] == gap_after[i]) gap_cnt[i] = gap_len[i];
                end
                if (rd[i] < len[i]) consumed = 0;
            end
            done = consumed && !pend && !stall;
            @(posedge clk);
            #1;
        end
        check({name, ":drained_in_budget"}, done, 1);
        check({name, ":byte_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check({name, ":byte"}, got_q[k], exp_q[k]);
        check({name, ":grant_count"}, got_own.size(), exp_own.size());
        for (int k = 0; k < exp_own.size() && k < got_own.size(); k++)
            check({name, ":grant_owner"}, got_own[k], exp_own[k]);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset:tx_valid", tx_valid, 0);
        check("reset:tx_data", tx_data, 8'h00);
        check("reset:grant", grant, 0);
        check("reset:req_ready", req_ready, 0);

        do_reset();
        load_str(0, "hi\n");
        load_str(1, "ok\n");
        build_expected();
        ready_mode = 1;
        run_stream("two_msgs", 200);

        do_reset();
        for (int k = 0; k < 70; k++) mem[0][k] = 8'h30 + 8'(k % 40);
        len[0] = 70; gap_after[0] = -1; gap_len[0] = 0;
        load_str(1, "ab\n");
        build_expected();
        ready_mode = 1;
        run_stream("long_burst", 1000);

        do_reset();
        load_str(0, "hi\n");
        load_str(1, "ok\n");
        build_expected();
        ready_mode = 2;
        run_stream("tx_stall", 300);

`ifdef UART_TX_ARB_LOCK_EN
        do_reset();
        load_str(0, "ABCDE\n");
        gap_after[0] = 3; gap_len[0] = 15;
        load_str(1, "xy\n");
        exp_q.delete(); exp_own.delete();
        expect_str("ABCDE\nxy\n");
        exp_own.push_back(2'b01); exp_own.push_back(2'b10);
        ready_mode = 1;
        run_stream("gap15_keeps", 300);

        do_reset();
        load_str(0, "ABCDE\n");
        gap_after[0] = 3; gap_len[0] = 16;
        load_str(1, "xy\n");
        exp_q.delete(); exp_own.delete();
        expect_str("ABCxy\nDE\n");
        exp_own.push_back(2'b01); exp_own.push_back(2'b10); exp_own.push_back(2'b01);
        ready_mode = 1;
        run_stream("gap16_releases", 300);
`endif

        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int r = 0; r < NREQ; r++) load_random(r, $urandom_range(1, 40));
            build_expected();
            ready_mode = 0;
            run_stream("random", 3000);
        end

        do_reset();
        req_valid = 2'b01;
        req_data  = {8'h00, 8'h6D};
        tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid:pre_tx_valid", tx_valid, 1);
        check("rst_mid:pre_grant", grant, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid:tx_valid", tx_valid, 0);
        check("rst_mid:grant", grant, 0);
        check("rst_mid:req_ready", req_ready, 0);
        req_valid = 2'b11;
        req_data  = {8'h6E, 8'h6D};
        tx_ready  = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (grant != '0) break;
            check("rst_mid:no_tx_before_grant", tx_valid, 0);
        end
        check("rst_mid:first_grant", grant, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
